m_dmem_lsu: RTL and testbench
=============================

# m_dmem_lsu

Parametrised, handshaked data memory for the RISC-V core. It supports byte, halfword and word loads and stores, little-endian, with sign or zero extension on loads. Each access has a configurable wait-state latency, so the pipeline can stall on a realistic memory timing. It replaces the fixed 64-word, word-only, combinational-read data memory in the memory stage.

## Interface

Parameters:
- ADDR_W, 6, word-address bits; depth = 2**ADDR_W words of 32 bits.
- LATENCY, 1, wait-state cycles between accept and response; legal range 1..15.

Ports:
- w_clk, input, 1, clock; all state updates on the rising edge.
- w_rst, input, 1, reset; asynchronous and active-high.
- w_req, input, 1, access request.
- w_we, input, 1, 1 = store, 0 = load; sampled with w_req.
- w_funct3, input, 3, RISC-V funct3 giving access size and sign.
- w_adr, input, 32, byte address.
- w_wd, input, 32, store data, right-aligned.
- w_ready, output, 1, block idle; a request is accepted on an edge where w_req=1 and w_ready=1.
- w_valid, output, 1, one-cycle response strobe.
- w_rd, output, 32, extended load data; valid while w_valid=1.
- w_err, output, 1, access rejected; valid while w_valid=1.

## Operation

- Memory array: 2**ADDR_W x 32. Word index = w_adr[ADDR_W+1:2]; higher address bits are ignored, so addresses wrap around. The array is initialised to 0 at time zero. Reset does not clear it.
- Loads, by funct3: 000 LB and 100 LBU select the byte lane w_adr[1:0]. 001 LH and 101 LHU select the halfword w_adr[1]. 010 LW returns the whole word. LB and LH sign-extend; LBU and LHU zero-extend.
- Stores, by funct3: 000 SB writes w_wd[7:0] to the addressed lane. 001 SH writes w_wd[15:0]. 010 SW writes the full word. Only the addressed lanes change.
- Illegal funct3 (loads 011/110/111, stores 011 and 1xx): w_err=1, no write, w_rd=0.
- FSM states:
  - IDLE: w_ready=1. On an accept edge, latch w_we, w_funct3, w_adr and w_wd, load the counter with LATENCY-1, and go to WAIT.
  - WAIT: on each edge with counter != 0, decrement the counter. On the edge with counter == 0:
    - a legal store commits to the array;
    - for a load, w_rd is registered;
    - w_err is registered;
    - the state goes to RESP.
  - RESP: w_valid=1 for exactly one cycle; the next edge returns to IDLE.
- w_req while not in IDLE is ignored. It is not queued.
- w_rd and w_err hold their values after RESP until the next response. For a store, w_rd=0.
- Reset, including mid-operation:
  - state becomes IDLE, the counter becomes 0, and any pending access is dropped;
  - a pending store never commits;
  - reset values: w_ready=1, w_valid=0, w_rd=0, w_err=0.
- A request presented while w_rst is high is not accepted.

## Timing

- Accept at edge E0. Commit or data capture at edge E(LATENCY). w_valid is high between E(LATENCY) and E(LATENCY+1). w_ready returns high after E(LATENCY+1).
- Throughput is one access per LATENCY+2 cycles.
- With LATENCY=1, w_valid is high in the second cycle after the accept edge.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- A load following a store to the same address returns the stored data, because the commit happens before the next accept.

## Configuration

- DMEM_ALIGN_CHECK_EN defined:
  - LH, LHU and SH with w_adr[0]=1 are misaligned;
  - LW and SW with w_adr[1:0]!=0 are misaligned;
  - a misaligned access gives w_err=1, no write, and w_rd=0.
- DMEM_ALIGN_CHECK_EN not defined:
  - no misalignment check is made;
  - halfword accesses ignore w_adr[0];
  - word accesses ignore w_adr[1:0];
  - w_err flags only illegal funct3.

## Test plan

- SW 0x8899AABB to 0x10, then LW 0x10 -> w_rd=0x8899AABB, w_err=0, and w_valid rises exactly LATENCY cycles after each accept edge.
- After that word, SB 0x11 to 0x12, then LW 0x10 -> 0x8811AABB. LB 0x12 -> 0x00000011. LBU 0x13 -> 0x00000088. LB 0x13 -> 0xFFFFFF88.
- LH 0x10 -> 0xFFFFAABB. LHU 0x12 -> 0x00008811. SH 0x1234 to 0x12, then LW 0x10 -> 0x1234AABB.
- ADDR_W=6: SW 0xDEADBEEF to 0x100, then LW 0x000 -> 0xDEADBEEF (wrap-around). w_req held high during WAIT -> only one access per LATENCY+2 cycles.
- LW at 0x11:
  - with DMEM_ALIGN_CHECK_EN: w_err=1, w_rd=0, memory unchanged.
  - without it: w_err=0, w_rd = word at 0x10.
  - funct3=011 -> w_err=1 in both builds.
- LATENCY=3: issue SW 0xFFFFFFFF to 0x20, assert w_rst during WAIT -> w_valid never pulses, w_ready=1 after reset, and LW 0x20 returns the prior value 0x00000000.

Source files
------------

// File: rtl/m_dmem_lsu.sv
// ---------------------------------------------------------------------------
// m_dmem_lsu
// Handshaked data memory for the RISC-V memory stage. Byte, halfword and word
// loads/stores (little-endian), sign/zero extension on loads, and a fixed
// number of wait states between accepting a request and responding.
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   defined     -> misaligned halfword/word accesses are rejected (w_err=1)
//   not defined -> halfword ignores w_adr[0], word ignores w_adr[1:0]
//
// Parameters:
//   ADDR_W  - word-address bits, depth = 2**ADDR_W words of 32 bits
//   LATENCY - wait-state cycles between accept and response (1..15)
//
// Ports:
//   w_clk    in   clock, rising edge
//   w_rst    in   asynchronous active-high reset
//   w_req    in   access request, accepted when w_ready=1
//   w_we     in   1 = store, 0 = load
//   w_funct3 in   RISC-V funct3 (size / sign)
//   w_adr    in   byte address (upper bits beyond the array wrap)
//   w_wd     in   right-aligned store data
//   w_ready  out  block idle
//   w_valid  out  one-cycle response strobe
//   w_rd     out  extended load data (0 for stores and errors)
//   w_err    out  access rejected (illegal funct3 or misaligned)
// ---------------------------------------------------------------------------
module m_dmem_lsu #(
  parameter int ADDR_W  = 6,
  parameter int LATENCY = 1
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_req,
  input  logic        w_we,
  input  logic [2:0]  w_funct3,
  input  logic [31:0] w_adr,
  input  logic [31:0] w_wd,
  output logic        w_ready,
  output logic        w_valid,
  output logic [31:0] w_rd,
  output logic        w_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [3:0]          cnt_r;
  logic                we_r;
  logic [2:0]          f3_r;
  logic [ADDR_W+1:0]   adr_r;
  logic [31:0]         wd_r;
  logic [31:0]         rd_r;
  logic                err_r;

  // Contents start at zero and are deliberately untouched by reset.
  logic [31:0]         mem_r [DEPTH] = '{default: 32'h0000_0000};

  logic                accept_s;
  logic                done_s;
  logic [ADDR_W-1:0]   idx_s;
  logic [31:0]         word_s;
  logic [31:0]         shifted_s;
  logic [7:0]          lane_s;
  logic [15:0]         half_s;
  logic                misal_s;
  logic                err_s;
  logic [31:0]         ld_s;
  logic [3:0]          wmask_s;
  logic [31:0]         wdat_s;
  logic                unused_s;

  // Address bits above the array are ignored so accesses wrap.
  assign unused_s = ^w_adr[31:ADDR_W+2];

  assign accept_s  = (state_r == S_IDLE) && w_req;
  assign done_s    = (state_r == S_WAIT) && (cnt_r == 4'd0);
  assign idx_s     = adr_r[ADDR_W+1:2];
  assign word_s    = mem_r[idx_s];
  assign shifted_s = word_s >> {adr_r[1:0], 3'b000};
  assign lane_s    = shifted_s[7:0];
  assign half_s    = adr_r[1] ? word_s[31:16] : word_s[15:0];

  // Misalignment detection for the latched access.
  always_comb begin
    misal_s = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    case (f3_r[1:0])
      2'b01:   misal_s = adr_r[0];
      2'b10:   misal_s = (adr_r[1:0] != 2'b00);
      default: misal_s = 1'b0;
    endcase
`else
    misal_s = 1'b0;
`endif
  end

  // Decode the latched access into load data, store lanes and error flag.
  always_comb begin
    err_s   = 1'b0;
    ld_s    = 32'h0000_0000;
    wmask_s = 4'b0000;
    wdat_s  = 32'h0000_0000;
    if (we_r) begin
      case (f3_r)
        3'b000: begin
          wmask_s = 4'b0001 << adr_r[1:0];
          wdat_s  = {4{wd_r[7:0]}};
        end
        3'b001: begin
          wmask_s = adr_r[1] ? 4'b1100 : 4'b0011;
          wdat_s  = {2{wd_r[15:0]}};
        end
        3'b010: begin
          wmask_s = 4'b1111;
          wdat_s  = wd_r;
        end
        default: err_s = 1'b1;
      endcase
    end else begin
      case (f3_r)
        3'b000:  ld_s = {{24{lane_s[7]}}, lane_s};
        3'b100:  ld_s = {24'h00_0000, lane_s};
        3'b001:  ld_s = {{16{half_s[15]}}, half_s};
        3'b101:  ld_s = {16'h0000, half_s};
        3'b010:  ld_s = word_s;
        default: err_s = 1'b1;
      endcase
    end
    // A rejected access neither writes nor returns data.
    if (misal_s) begin
      err_s   = 1'b1;
      ld_s    = 32'h0000_0000;
      wmask_s = 4'b0000;
    end else if (err_s) begin
      ld_s    = 32'h0000_0000;
      wmask_s = 4'b0000;
    end else begin
      ld_s    = ld_s;
    end
  end

  // FSM state register.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (w_req) state_nxt_s = S_WAIT;
        else       state_nxt_s = S_IDLE;
      end
      S_WAIT: begin
        if (cnt_r == 4'd0) state_nxt_s = S_RESP;
        else               state_nxt_s = S_WAIT;
      end
      S_RESP:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Request latch, wait-state counter and registered response.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      cnt_r <= 4'd0;
      we_r  <= 1'b0;
      f3_r  <= 3'b000;
      adr_r <= '0;
      wd_r  <= 32'h0000_0000;
      rd_r  <= 32'h0000_0000;
      err_r <= 1'b0;
    end else begin
      if (accept_s) begin
        cnt_r <= 4'(LATENCY - 1);
        we_r  <= w_we;
        f3_r  <= w_funct3;
        adr_r <= w_adr[ADDR_W+1:0];
        wd_r  <= w_wd;
      end else if ((state_r == S_WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (done_s) begin
        rd_r  <= ld_s;
        err_r <= err_s;
      end
    end
  end

  // Store commit on the final wait edge; a reset in flight suppresses it.
  always_ff @(posedge w_clk) begin
    if (done_s && !w_rst) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_s[i]) mem_r[idx_s][8*i +: 8] <= wdat_s[8*i +: 8];
      end
    end
  end

  assign w_ready = (state_r == S_IDLE);
  assign w_valid = (state_r == S_RESP);
  assign w_rd    = rd_r;
  assign w_err   = err_r;

endmodule

// File: tb/tb_m_dmem_lsu.sv
module tb_m_dmem_lsu;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic        w_req = 1'b0;
  logic        w_we = 1'b0;
  logic [2:0]  w_funct3 = 3'b000;
  logic [31:0] w_adr = 32'h0;
  logic [31:0] w_wd = 32'h0;
  logic        w_ready1, w_valid1, w_err1;
  logic        w_ready3, w_valid3, w_err3;
  logic [31:0] w_rd1, w_rd3;

  int vecs = 0;
  int errs = 0;

  always #5 w_clk = ~w_clk;

  m_dmem_lsu #(.ADDR_W(6), .LATENCY(1)) u_dut1 (
    .w_clk(w_clk), .w_rst(w_rst), .w_req(w_req), .w_we(w_we),
    .w_funct3(w_funct3), .w_adr(w_adr), .w_wd(w_wd),
    .w_ready(w_ready1), .w_valid(w_valid1), .w_rd(w_rd1), .w_err(w_err1));

  m_dmem_lsu #(.ADDR_W(6), .LATENCY(3)) u_dut3 (
    .w_clk(w_clk), .w_rst(w_rst), .w_req(w_req), .w_we(w_we),
    .w_funct3(w_funct3), .w_adr(w_adr), .w_wd(w_wd),
    .w_ready(w_ready3), .w_valid(w_valid3), .w_rd(w_rd3), .w_err(w_err3));

  // One access issued to both instances; checks latency, data, error, hold.
  task automatic access(input logic we, input logic [2:0] f3,
                        input logic [31:0] adr, input logic [31:0] wd,
                        input logic [31:0] e_rd1, input logic [31:0] e_rd3,
                        input logic e_err, input string name);
    int first1 = -1, first3 = -1, n1 = 0, n3 = 0;
    logic [31:0] rd1 = 32'hx, rd3 = 32'hx;
    logic er1 = 1'bx, er3 = 1'bx;
    @(negedge w_clk);
    vecs++;
    if (w_ready1 !== 1'b1 || w_ready3 !== 1'b1) begin
      errs++; $display("FAIL %s ready_before got %b/%b exp 1/1", name, w_ready1, w_ready3);
    end
    w_req = 1'b1; w_we = we; w_funct3 = f3; w_adr = adr; w_wd = wd;
    @(posedge w_clk);
    @(negedge w_clk);
    w_req = 1'b0;
    vecs++;
    if (w_ready1 !== 1'b0 || w_ready3 !== 1'b0) begin
      errs++; $display("FAIL %s busy got %b/%b exp 0/0", name, w_ready1, w_ready3);
    end
    for (int k = 1; k <= 5; k++) begin
      @(posedge w_clk);
      @(negedge w_clk);
      if (w_valid1 === 1'b1) begin
        n1++; if (first1 < 0) first1 = k; rd1 = w_rd1; er1 = w_err1;
      end
      if (w_valid3 === 1'b1) begin
        n3++; if (first3 < 0) first3 = k; rd3 = w_rd3; er3 = w_err3;
      end
    end
    vecs++;
    if (first1 != 1 || n1 != 1) begin
      errs++; $display("FAIL %s lat1_timing got first=%0d n=%0d exp first=1 n=1", name, first1, n1);
    end
    vecs++;
    if (first3 != 3 || n3 != 1) begin
      errs++; $display("FAIL %s lat3_timing got first=%0d n=%0d exp first=3 n=1", name, first3, n3);
    end
    vecs++;
    if (rd1 !== e_rd1 || er1 !== e_err) begin
      errs++; $display("FAIL %s lat1_data got rd=%h err=%b exp rd=%h err=%b", name, rd1, er1, e_rd1, e_err);
    end
    vecs++;
    if (rd3 !== e_rd3 || er3 !== e_err) begin
      errs++; $display("FAIL %s lat3_data got rd=%h err=%b exp rd=%h err=%b", name, rd3, er3, e_rd3, e_err);
    end
    vecs++;
    if (w_rd1 !== e_rd1 || w_rd3 !== e_rd3 || w_err1 !== e_err || w_err3 !== e_err ||
        w_ready1 !== 1'b1 || w_ready3 !== 1'b1) begin
      errs++; $display("FAIL %s hold got rd=%h/%h err=%b/%b rdy=%b/%b exp rd=%h/%h err=%b rdy=1",
                       name, w_rd1, w_rd3, w_err1, w_err3, w_ready1, w_ready3, e_rd1, e_rd3, e_err);
    end
  endtask

  task automatic test_reset();
    w_req = 1'b1; w_we = 1'b1; w_funct3 = 3'b010; w_adr = 32'h10; w_wd = 32'hFFFF_FFFF;
    repeat (3) @(posedge w_clk);
    @(negedge w_clk);
    vecs++;
    if (w_ready1 !== 1'b1 || w_valid1 !== 1'b0 || w_rd1 !== 32'h0 || w_err1 !== 1'b0 ||
        w_ready3 !== 1'b1 || w_valid3 !== 1'b0 || w_rd3 !== 32'h0 || w_err3 !== 1'b0) begin
      errs++; $display("FAIL reset_values got rdy=%b/%b vld=%b/%b rd=%h/%h err=%b/%b exp 1,0,0,0",
                       w_ready1, w_ready3, w_valid1, w_valid3, w_rd1, w_rd3, w_err1, w_err3);
    end
    w_rst = 1'b0; w_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge w_clk);
      vecs++;
      if (w_valid1 !== 1'b0 || w_valid3 !== 1'b0 || w_ready1 !== 1'b1 || w_ready3 !== 1'b1) begin
        errs++; $display("FAIL req_in_reset got vld=%b/%b rdy=%b/%b exp vld=0 rdy=1",
                         w_valid1, w_valid3, w_ready1, w_ready3);
      end
    end
  endtask

  task automatic test_word_byte_half();
    access(1'b1, 3'b010, 32'h10, 32'h8899_AABB, 32'h0, 32'h0, 1'b0, "sw_10");
    access(1'b0, 3'b010, 32'h10, 32'h0, 32'h8899_AABB, 32'h8899_AABB, 1'b0, "lw_10");
    access(1'b1, 3'b000, 32'h12, 32'hABCD_EF11, 32'h0, 32'h0, 1'b0, "sb_12");
    access(1'b0, 3'b010, 32'h10, 32'h0, 32'h8811_AABB, 32'h8811_AABB, 1'b0, "lw_after_sb");
    access(1'b0, 3'b000, 32'h12, 32'h0, 32'h0000_0011, 32'h0000_0011, 1'b0, "lb_12");
    access(1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_0088, 32'h0000_0088, 1'b0, "lbu_13");
    access(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FF88, 32'hFFFF_FF88, 1'b0, "lb_13");
    access(1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFBB, 32'hFFFF_FFBB, 1'b0, "lb_10");
    access(1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFF_AABB, 32'hFFFF_AABB, 1'b0, "lh_10");
    access(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_8811, 32'h0000_8811, 1'b0, "lhu_12");
    access(1'b1, 3'b001, 32'h12, 32'h5A5A_1234, 32'h0, 32'h0, 1'b0, "sh_12");
    access(1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_AABB, 32'h1234_AABB, 1'b0, "lw_after_sh");
  endtask

  task automatic test_wrap();
    access(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, "sw_100");
    access(1'b0, 3'b010, 32'h000, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "lw_wrap");
  endtask

  task automatic test_errors();
`ifdef DMEM_ALIGN_CHECK_EN
    access(1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 32'h0, 1'b1, "lw_misaligned");
    access(1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 32'h0, 1'b1, "lh_misaligned");
`else
    access(1'b0, 3'b010, 32'h11, 32'h0, 32'h1234_AABB, 32'h1234_AABB, 1'b0, "lw_unaligned");
    access(1'b0, 3'b001, 32'h13, 32'h0, 32'h0000_1234, 32'h0000_1234, 1'b0, "lh_unaligned");
`endif
    access(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 32'h0, 1'b1, "ld_f3_011");
    access(1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1, "st_f3_100");
    access(1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_AABB, 32'h1234_AABB, 1'b0, "lw_unchanged");
  endtask

  // Request held high: one access per LATENCY+2 cycles, no queuing.
  task automatic test_back_to_back();
    int n1 = 0, n3 = 0;
    @(negedge w_clk);
    w_req = 1'b1; w_we = 1'b0; w_funct3 = 3'b010; w_adr = 32'h10; w_wd = 32'h0;
    @(posedge w_clk);
    for (int k = 1; k <= 9; k++) begin
      @(posedge w_clk);
      @(negedge w_clk);
      if (w_valid1 === 1'b1) n1++;
      if (w_valid3 === 1'b1) n3++;
    end
    w_req = 1'b0;
    repeat (6) @(negedge w_clk);
    vecs++;
    if (n1 != 3 || n3 != 2) begin
      errs++; $display("FAIL back_to_back got pulses=%0d/%0d exp 3/2", n1, n3);
    end
  endtask

  // Reset while the LATENCY=3 store is still waiting: it must never commit.
  task automatic test_reset_mid_wait();
    int n3 = 0;
    @(negedge w_clk);
    w_req = 1'b1; w_we = 1'b1; w_funct3 = 3'b010; w_adr = 32'h20; w_wd = 32'hFFFF_FFFF;
    @(posedge w_clk);
    @(negedge w_clk);
    w_req = 1'b0;
    @(posedge w_clk);
    @(negedge w_clk);
    w_rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) w_rst = 1'b0;
      @(posedge w_clk);
      @(negedge w_clk);
      if (w_valid3 === 1'b1) n3++;
    end
    vecs++;
    if (n3 != 0) begin
      errs++; $display("FAIL rst_mid_wait_valid got pulses=%0d exp 0", n3);
    end
    vecs++;
    if (w_ready1 !== 1'b1 || w_ready3 !== 1'b1 || w_rd3 !== 32'h0 || w_err3 !== 1'b0) begin
      errs++; $display("FAIL rst_mid_wait_state got rdy=%b/%b rd3=%h err3=%b exp 1/1 0 0",
                       w_ready1, w_ready3, w_rd3, w_err3);
    end
    // The LATENCY=1 instance had already committed before the reset.
    access(1'b0, 3'b010, 32'h20, 32'h0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "lw_20_after_rst");
  endtask

  initial begin
    test_reset();
    test_word_byte_half();
    test_wrap();
    test_errors();
    test_back_to_back();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
